// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control and a saturating bubble counter.
// Latency: one cycle from ID inputs to EX outputs; hold_i freezes everything, and stall_o asks ID/IF to repeat the instruction.
module idex_stage_reg #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic            aluSrc_i,
  input  logic [2:0]      memVector_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [1:0]      WBackVector_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1Data_i,
  input  logic [XLEN-1:0] rs2Data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [RAW-1:0]  rs1Addr_i,
  input  logic [RAW-1:0]  rs2Addr_i,
  input  logic [RAW-1:0]  rdAddr_i,
  input  logic            useRs1_i,
  input  logic            useRs2_i,
  input  logic [3:0]      funct_i,
  output logic            stall_o,
  output logic            aluSrc_o,
  output logic [2:0]      memVector_o,
  output logic [1:0]      ALUOp_o,
  output logic [1:0]      WBackVector_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs1Data_o,
  output logic [XLEN-1:0] rs2Data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [RAW-1:0]  rs1Addr_o,
  output logic [RAW-1:0]  rs2Addr_o,
  output logic [RAW-1:0]  rdAddr_o,
  output logic [3:0]      funct_o,
  output logic            valid_o,
  output logic [15:0]     bubbleCnt_o
);

  logic exIsLoad;
  logic rs1Hit;
  logic rs2Hit;
  logic insertBubble;
  logic doLoad;

  // A flush discards the ID instruction anyway, so it never needs to stall.
  assign exIsLoad = valid_o & memVector_o[2] & (rdAddr_o != '0);
  assign rs1Hit   = useRs1_i & (rs1Addr_i == rdAddr_o);
  assign rs2Hit   = useRs2_i & (rs2Addr_i == rdAddr_o);
  assign stall_o  = exIsLoad & (rs1Hit | rs2Hit) & ~flush_i;

  assign insertBubble = ~hold_i & (flush_i | stall_o);
  assign doLoad       = ~hold_i & ~flush_i & ~stall_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      aluSrc_o      <= 1'b0;
      memVector_o   <= '0;
      ALUOp_o       <= '0;
      WBackVector_o <= '0;
      valid_o       <= 1'b0;
    end else if (insertBubble) begin
      aluSrc_o      <= 1'b0;
      memVector_o   <= '0;
      ALUOp_o       <= '0;
      WBackVector_o <= '0;
      valid_o       <= 1'b0;
    end else if (doLoad) begin
      aluSrc_o      <= aluSrc_i;
      memVector_o   <= memVector_i;
      ALUOp_o       <= ALUOp_i;
      WBackVector_o <= WBackVector_i;
      valid_o       <= 1'b1;
    end
  end

  // Data fields only move on a real load; bubbles leave them as they were.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_o      <= '0;
      rs1Data_o <= '0;
      rs2Data_o <= '0;
      imm_o     <= '0;
      rs1Addr_o <= '0;
      rs2Addr_o <= '0;
      rdAddr_o  <= '0;
      funct_o   <= '0;
    end else if (doLoad) begin
      pc_o      <= pc_i;
      rs1Data_o <= rs1Data_i;
      rs2Data_o <= rs2Data_i;
      imm_o     <= imm_i;
      rs1Addr_o <= rs1Addr_i;
      rs2Addr_o <= rs2Addr_i;
      rdAddr_o  <= rdAddr_i;
      funct_o   <= funct_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bubbleCnt_o <= '0;
    end else if (insertBubble && (bubbleCnt_o != 16'hFFFF)) begin
      bubbleCnt_o <= bubbleCnt_o + 16'd1;
    end
  end

endmodule
